// File: rtl/pc_unit_pkg.sv
// -----------------------------------------------------------------------------
// pc_unit_pkg
//   Shared types and constants for the program-counter unit.
//   - pc_state_e        : sequencer state (WARM / RUN / HALT), 2-bit encoding
//   - DEF_RESET_VECTOR  : default PC after reset
//   - DEF_TRAP_VECTOR   : default PC loaded on a trap or misaligned redirect
//   - pc_update_req()   : true when a trap or redirect is requesting a PC load
// -----------------------------------------------------------------------------
package pc_unit_pkg;

    typedef enum logic [1:0] {
        ST_WARM = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

    // A trap or any redirect (aligned or not) loads a new PC and forces RUN.
    function automatic logic pc_update_req(input logic trap, input logic redir);
        return trap | redir;
    endfunction

endpackage

// File: rtl/pc_unit_ena_seq.sv
// -----------------------------------------------------------------------------
// pc_ena_seq
//   Warm-up counter and run/halt state machine for the PC unit.
//   After reset it spends ENA_DELAY cycles in WARM, then enters RUN. In RUN a
//   halt request moves it to HALT unless a trap/redirect is taken the same
//   cycle. HALT returns to RUN on a trap/redirect or when halt is released.
//   Ports:
//     clk_i, rst_ni      clock, asynchronous active-low reset
//     halt_req_i         level request to stop fetching
//     trap_req_i         trap request
//     redir_valid_i      redirect request
//     ena_o              system enable (registered; 1 in RUN and HALT)
//     pc_valid_o         fetch address valid (registered; 1 in RUN only)
//     state_o            current state, consumed by the PC datapath
// -----------------------------------------------------------------------------
module pc_ena_seq
    import pc_unit_pkg::*;
#(
    parameter int unsigned ENA_DELAY = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      halt_req_i,
    input  logic      trap_req_i,
    input  logic      redir_valid_i,
    output logic      ena_o,
    output logic      pc_valid_o,
    output pc_state_e state_o
);

    localparam int unsigned CNT_W = (ENA_DELAY > 1) ? $clog2(ENA_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ENA_DELAY - 1);

    pc_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ena_q;
    logic             pc_valid_q;

    // Outputs are updated together with the state so they line up with it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_WARM;
            cnt_q      <= '0;
            ena_q      <= 1'b0;
            pc_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_WARM: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q    <= ST_RUN;
                        ena_q      <= 1'b1;
                        pc_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    // A PC load in the same cycle defers the halt by one cycle.
                    if (halt_req_i && !pc_update_req(trap_req_i, redir_valid_i)) begin
                        state_q    <= ST_HALT;
                        pc_valid_q <= 1'b0;
                    end
                end
                ST_HALT: begin
                    if (pc_update_req(trap_req_i, redir_valid_i) || !halt_req_i) begin
                        state_q    <= ST_RUN;
                        pc_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_WARM;
                    cnt_q      <= '0;
                    ena_q      <= 1'b0;
                    pc_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ena_o      = ena_q;
    assign pc_valid_o = pc_valid_q;
    assign state_o    = state_q;

endmodule

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
//   Program-counter unit for the fetch stage. Holds curr_pc, advances it by
//   INSTR_BYTES on an accepted fetch, and takes traps and branch/jump
//   redirects. Misaligned redirect targets are converted into a trap, with the
//   offending target recorded in epc and a one-cycle misalign_err pulse.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     ena                 system enable (RUN and HALT)
//     pc_valid            curr_pc is a valid fetch address
//     if_ready            fetch stage accepts curr_pc this cycle
//     redir_valid         redirect request, target on redir_target
//     trap_req            trap request
//     halt_req            stop fetching (level)
//     curr_pc             current program counter
//     epc                 exception PC of the last trap / misaligned target
//     misalign_err        one-cycle pulse on a misaligned redirect
// -----------------------------------------------------------------------------
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned            PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = PC_WIDTH'(DEF_RESET_VECTOR),
    parameter logic [PC_WIDTH-1:0]    TRAP_VECTOR  = PC_WIDTH'(DEF_TRAP_VECTOR),
    parameter int unsigned            INSTR_BYTES  = 4,
    parameter int unsigned            ENA_DELAY    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                ena,
    output logic                pc_valid,
    input  logic                if_ready,
    input  logic                redir_valid,
    input  logic [PC_WIDTH-1:0] redir_target,
    input  logic                trap_req,
    input  logic                halt_req,
    output logic [PC_WIDTH-1:0] curr_pc,
    output logic [PC_WIDTH-1:0] epc,
    output logic                misalign_err
);

    // Low address bits that must be zero; all-zero when INSTR_BYTES is 1.
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(INSTR_BYTES - 1);
    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(INSTR_BYTES);

    pc_state_e           state;
    logic [PC_WIDTH-1:0] pc_q,  pc_d;
    logic [PC_WIDTH-1:0] epc_q, epc_d;
    logic                mis_q, mis_d;
    logic                target_misaligned;

    pc_ena_seq #(
        .ENA_DELAY (ENA_DELAY)
    ) u_ena_seq (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .halt_req_i    (halt_req),
        .trap_req_i    (trap_req),
        .redir_valid_i (redir_valid),
        .ena_o         (ena),
        .pc_valid_o    (pc_valid),
        .state_o       (state)
    );

    assign target_misaligned = |(redir_target & ALIGN_MASK);

    // Trap/redirect act in both RUN and HALT; sequential advance only in RUN
    // with no halt pending. The cycle that leaves HALT never advances.
    always_comb begin
        pc_d  = pc_q;
        epc_d = epc_q;
        mis_d = 1'b0;
        if (state == ST_RUN || state == ST_HALT) begin
            if (trap_req) begin
                pc_d  = TRAP_VECTOR;
                epc_d = pc_q;
            end else if (redir_valid) begin
                if (target_misaligned) begin
                    pc_d  = TRAP_VECTOR;
                    epc_d = redir_target;
                    mis_d = 1'b1;
                end else begin
                    pc_d = redir_target;
                end
            end else if (state == ST_RUN && !halt_req && if_ready) begin
                pc_d = pc_q + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_VECTOR;
            epc_q <= '0;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            mis_q <= mis_d;
        end
    end

    assign curr_pc      = pc_q;
    assign epc          = epc_q;
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_ready;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        trap_req;
    logic        halt_req;

    logic        ena0, pc_valid0, mis0;
    logic [31:0] pc0, epc0;
    logic        ena1, pc_valid1, mis1;
    logic [31:0] pc1, epc1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_unit #(
        .PC_WIDTH     (32),
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100),
        .INSTR_BYTES  (4),
        .ENA_DELAY    (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena0),
        .pc_valid     (pc_valid0),
        .if_ready     (if_ready),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .trap_req     (trap_req),
        .halt_req     (halt_req),
        .curr_pc      (pc0),
        .epc          (epc0),
        .misalign_err (mis0)
    );

    // Same stimulus, reset vector just below the wrap point.
    pc_unit #(
        .PC_WIDTH     (32),
        .RESET_VECTOR (32'hFFFF_FFFC),
        .TRAP_VECTOR  (32'h0000_0100),
        .INSTR_BYTES  (4),
        .ENA_DELAY    (2)
    ) dut_wrap (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena1),
        .pc_valid     (pc_valid1),
        .if_ready     (if_ready),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .trap_req     (trap_req),
        .halt_req     (halt_req),
        .curr_pc      (pc1),
        .epc          (epc1),
        .misalign_err (mis1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        if_ready     = 1'b1;
        redir_valid  = 1'b0;
        redir_target = '0;
        trap_req     = 1'b0;
        halt_req     = 1'b0;
        step();
        step();

        // Reset state
        check("rst_ena",      32'(ena0),      32'd0);
        check("rst_pc_valid", 32'(pc_valid0), 32'd0);
        check("rst_pc",       pc0,            32'h0);
        check("rst_epc",      epc0,           32'h0);
        check("rst_mis",      32'(mis0),      32'd0);
        check("rst_pc_wrap",  pc1,            32'hFFFF_FFFC);

        // Warm-up: two cycles with ena/pc_valid low, redirect ignored
        rst_n        = 1'b1;
        redir_valid  = 1'b1;
        redir_target = 32'h0000_0500;
        step();
        check("warm1_ena",      32'(ena0),      32'd0);
        check("warm1_pc_valid", 32'(pc_valid0), 32'd0);
        check("warm1_pc",       pc0,            32'h0);
        redir_valid = 1'b0;
        step();
        check("warm2_ena",      32'(ena0),      32'd1);
        check("warm2_pc_valid", 32'(pc_valid0), 32'd1);
        check("warm2_pc",       pc0,            32'h0);
        check("warm2_pc_wrap",  pc1,            32'hFFFF_FFFC);

        // Sequential advance, wrap on the second instance
        step();
        check("seq_pc4",  pc0, 32'h4);
        check("wrap_pc0", pc1, 32'h0);
        step();
        check("seq_pc8",  pc0, 32'h8);
        check("wrap_pc4", pc1, 32'h4);

        // Stall for three cycles
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc0, 32'h8);
        end
        if_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("seq_pc20", pc0, 32'h20);

        // Aligned redirect without if_ready
        if_ready     = 1'b0;
        redir_valid  = 1'b1;
        redir_target = 32'h80;
        step();
        check("redir_pc",       pc0,            32'h80);
        check("redir_pc_valid", 32'(pc_valid0), 32'd1);
        check("redir_mis",      32'(mis0),      32'd0);

        // Misaligned redirect from 'h40
        redir_target = 32'h40;
        step();
        check("redir40_pc", pc0, 32'h40);
        redir_target = 32'h82;
        step();
        check("mis_pc",  pc0,        32'h100);
        check("mis_epc", epc0,       32'h82);
        check("mis_err", 32'(mis0),  32'd1);
        redir_valid = 1'b0;
        step();
        check("mis_err_pulse", 32'(mis0), 32'd0);
        check("mis_pc_hold",   pc0,       32'h100);

        // Trap beats a simultaneous aligned redirect
        redir_valid  = 1'b1;
        redir_target = 32'h40;
        step();
        check("redir40b_pc", pc0, 32'h40);
        trap_req     = 1'b1;
        redir_target = 32'h80;
        step();
        check("trap_pc",  pc0,       32'h100);
        check("trap_epc", epc0,      32'h40);
        check("trap_mis", 32'(mis0), 32'd0);
        trap_req = 1'b0;

        // Halt at 'h10 and release
        redir_target = 32'h10;
        step();
        check("redir10_pc", pc0, 32'h10);
        redir_valid = 1'b0;
        if_ready    = 1'b1;
        halt_req    = 1'b1;
        step();
        check("halt_pc_valid", 32'(pc_valid0), 32'd0);
        check("halt_ena",      32'(ena0),      32'd1);
        check("halt_pc",       pc0,            32'h10);
        step();
        check("halt2_pc", pc0, 32'h10);
        halt_req = 1'b0;
        step();
        check("unhalt_pc_valid", 32'(pc_valid0), 32'd1);
        check("unhalt_pc",       pc0,            32'h10);
        step();
        check("resume_pc", pc0, 32'h14);

        // Trap with halt requested: trap wins, halt follows a cycle later
        halt_req = 1'b1;
        trap_req = 1'b1;
        step();
        check("trap_halt_pc",       pc0,            32'h100);
        check("trap_halt_epc",      epc0,           32'h14);
        check("trap_halt_pc_valid", 32'(pc_valid0), 32'd1);
        trap_req = 1'b0;
        step();
        check("late_halt_pc_valid", 32'(pc_valid0), 32'd0);
        check("late_halt_pc",       pc0,            32'h100);

        // Redirect out of HALT, then halt re-taken
        redir_valid  = 1'b1;
        redir_target = 32'h200;
        step();
        check("halt_redir_pc",       pc0,            32'h200);
        check("halt_redir_pc_valid", 32'(pc_valid0), 32'd1);
        redir_valid = 1'b0;
        step();
        check("rehalt_pc_valid", 32'(pc_valid0), 32'd0);
        check("rehalt_pc",       pc0,            32'h200);

        // Asynchronous reset mid-HALT, between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ena",      32'(ena0),      32'd0);
        check("arst_pc_valid", 32'(pc_valid0), 32'd0);
        check("arst_pc",       pc0,            32'h0);
        check("arst_epc",      epc0,           32'h0);
        check("arst_mis",      32'(mis0),      32'd0);

        // Warm-up restarts
        halt_req = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("rewarm1_ena", 32'(ena0), 32'd0);
        step();
        check("rewarm2_ena",      32'(ena0),      32'd1);
        check("rewarm2_pc_valid", 32'(pc_valid0), 32'd1);
        step();
        check("rewarm_pc4", pc0, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #20000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
